// File: rtl/dmem_dma_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_dma_arbiter_pkg
// Brief    : Shared types and helpers for the data-memory DMA port arbiter.
// Revision : 1.0
// ============================================================================
package dmem_dma_arbiter_pkg;

  // Width of a port index for a given requester count (2..8 requesters)
  function automatic int port_idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_dma_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int   k;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_dma_arbiter
// Brief    : Shares one data-memory DMA port among PORTS requesters with
//            round-robin arbitration, burst lock and tagged read returns.
// Revision : 1.0
// ============================================================================
module dmem_dma_arbiter
  import dmem_dma_arbiter_pkg::*;
#(
  parameter int PORTS           = 3,
  parameter int DATA_WIDTH      = 64,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int DMEM_SIZE_BYTES = 32768,
  parameter int RD_LATENCY      = 1,
  localparam int DMEM_ADDR_WIDTH = $clog2(DMEM_SIZE_BYTES),
  localparam int IDX_W           = port_idx_w(PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              req_valid,
  output logic [PORTS-1:0]              req_ready,
  input  logic [PORTS-1:0]              req_last,
  input  logic [PORTS-1:0]              req_ren,
  input  logic [PORTS*STRB_WIDTH-1:0]   req_wen,
  input  logic [PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [PORTS*DATA_WIDTH-1:0]   req_wr_data,
  output logic [PORTS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          data_dma_en,
  output logic                          data_dma_ren,
  output logic [STRB_WIDTH-1:0]         data_dma_wen,
  output logic [ADDR_WIDTH-1:0]         data_dma_addr,
  output logic [DATA_WIDTH-1:0]         data_dma_wr_data,
  input  logic [DATA_WIDTH-1:0]         data_dma_rd_data,
  output logic                          err_oob,
  output logic [IDX_W-1:0]              err_port,
  input  logic                          err_clear
);

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_lock_port;
  logic [RD_LATENCY-1:0]  r_pipe_vld;
  logic [RD_LATENCY-1:0]  r_pipe_oob;
  logic [IDX_W-1:0]       r_pipe_port [RD_LATENCY];
  logic                   r_err_oob;
  logic [IDX_W-1:0]       r_err_port;

  logic [PORTS-1:0]       w_rr_grant;
  logic [IDX_W-1:0]       w_rr_idx;
  logic [PORTS-1:0]       w_grant;
  logic [IDX_W-1:0]       w_idx;
  logic [IDX_W-1:0]       w_next_ptr;
  logic                   w_acc;
  logic                   w_fwd;
  logic                   w_oob;
  logic                   w_sel_ren;
  logic                   w_sel_last;
  logic [STRB_WIDTH-1:0]  w_sel_wen;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;

  rr_arbiter #(
    .N     (PORTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_rr_grant),
    .grant_idx (w_rr_idx)
  );

  // While locked only the burst owner can be granted; reset masks everything
  always_comb begin
    w_grant = '0;
    w_idx   = r_lock_port;
    if (!rst) begin
      if (r_state == ST_LOCKED) begin
        w_grant[r_lock_port] = req_valid[r_lock_port];
      end else begin
        w_grant = w_rr_grant;
        w_idx   = w_rr_idx;
      end
    end
  end

  assign req_ready   = w_grant;
  assign w_acc       = |w_grant;
  assign w_sel_ren   = req_ren[w_idx];
  assign w_sel_last  = req_last[w_idx];
  assign w_sel_wen   = req_wen[w_idx*STRB_WIDTH +: STRB_WIDTH];
  assign w_sel_addr  = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = req_wr_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_oob       = (w_sel_addr >> DMEM_ADDR_WIDTH) != '0;
  assign w_fwd       = w_acc && !w_oob;
  assign w_next_ptr  = (w_idx == IDX_W'(PORTS - 1)) ? '0 : w_idx + 1'b1;

  assign data_dma_en      = w_fwd;
  assign data_dma_ren     = w_fwd & w_sel_ren;
  assign data_dma_wen     = w_fwd ? w_sel_wen   : '0;
  assign data_dma_addr    = w_fwd ? w_sel_addr  : '0;
  assign data_dma_wr_data = w_fwd ? w_sel_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_lock_port <= '0;
      r_pipe_vld  <= '0;
      r_pipe_oob  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_port[i] <= '0;
      r_err_oob   <= 1'b0;
      r_err_port  <= '0;
    end else begin
      if (w_acc) begin
        r_rr_ptr <= w_next_ptr;
        if (w_sel_last) begin
          r_state <= ST_IDLE;
        end else begin
          r_state     <= ST_LOCKED;
          r_lock_port <= w_idx;
        end
      end

      // A new error outranks a simultaneous clear
      if (w_acc && w_oob && (!r_err_oob || err_clear)) begin
        r_err_oob  <= 1'b1;
        r_err_port <= w_idx;
      end else if (err_clear) begin
        r_err_oob  <= 1'b0;
        r_err_port <= '0;
      end

      r_pipe_vld[0]  <= w_acc & w_sel_ren;
      r_pipe_oob[0]  <= w_oob;
      r_pipe_port[0] <= w_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_oob[i]  <= r_pipe_oob[i-1];
        r_pipe_port[i] <= r_pipe_port[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_pipe_vld[RD_LATENCY-1]) rsp_valid[r_pipe_port[RD_LATENCY-1]] = 1'b1;
  end

  assign rsp_data = (r_pipe_vld[RD_LATENCY-1] && !r_pipe_oob[RD_LATENCY-1])
                    ? data_dma_rd_data : '0;
  assign err_oob  = r_err_oob;
  assign err_port = r_err_port;

endmodule
`default_nettype wire

// File: tb/tb_dmem_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_dma_arbiter
// Brief    : Directed self-checking bench for dmem_dma_arbiter (RD_LATENCY=2).
// Revision : 1.0
// ============================================================================
module tb_dmem_dma_arbiter;

  localparam int P  = 3;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int AW = 16;

  logic            clk;
  logic            rst;
  logic [P-1:0]    req_valid;
  logic [P-1:0]    req_ready;
  logic [P-1:0]    req_last;
  logic [P-1:0]    req_ren;
  logic [P*SW-1:0] req_wen;
  logic [P*AW-1:0] req_addr;
  logic [P*DW-1:0] req_wr_data;
  logic [P-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            data_dma_en;
  logic            data_dma_ren;
  logic [SW-1:0]   data_dma_wen;
  logic [AW-1:0]   data_dma_addr;
  logic [DW-1:0]   data_dma_wr_data;
  logic [DW-1:0]   data_dma_rd_data;
  logic            err_oob;
  logic [1:0]      err_port;
  logic            err_clear;

  logic [DW-1:0]   m1;
  logic [DW-1:0]   m2;

  int n_cmp = 0;
  int n_err = 0;

  dmem_dma_arbiter #(
    .PORTS           (P),
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .DMEM_SIZE_BYTES (32768),
    .RD_LATENCY      (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_last         (req_last),
    .req_ren          (req_ren),
    .req_wen          (req_wen),
    .req_addr         (req_addr),
    .req_wr_data      (req_wr_data),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .data_dma_en      (data_dma_en),
    .data_dma_ren     (data_dma_ren),
    .data_dma_wen     (data_dma_wen),
    .data_dma_addr    (data_dma_addr),
    .data_dma_wr_data (data_dma_wr_data),
    .data_dma_rd_data (data_dma_rd_data),
    .err_oob          (err_oob),
    .err_port         (err_port),
    .err_clear        (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] a);
    return {16'hD00D, 32'h1234_5678, a};
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int p, input logic [AW-1:0] a);
    return {16'hCAFE, 16'(p), 16'h0000, a};
  endfunction

  // Two-cycle memory: returns a pattern of whatever address was presented
  always @(posedge clk) begin
    m1 <= mem_of(data_dma_addr);
    m2 <= m1;
  end
  assign data_dma_rd_data = m2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    req_valid   = '0;
    req_last    = '1;
    req_ren     = '0;
    req_wen     = '0;
    req_addr    = '0;
    req_wr_data = '0;
  endtask

  task automatic set_port(input int p, input logic ren, input logic [SW-1:0] wen,
                          input logic [AW-1:0] addr, input logic last);
    req_valid[p]               = 1'b1;
    req_ren[p]                 = ren;
    req_last[p]                = last;
    req_wen[p*SW +: SW]        = wen;
    req_addr[p*AW +: AW]       = addr;
    req_wr_data[p*DW +: DW]    = wdata_of(p, addr);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    err_clear = 1'b0;
    clear_all();
    for (int p = 0; p < P; p++) set_port(p, 1'b0, 8'hFF, 16'h0100 + 16'(p * 8), 1'b1);
    #2;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_en", 64'(data_dma_en), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_err_oob", 64'(err_oob), 64'h0);
    chk("rst_err_port", 64'(err_port), 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // Round robin over three always-valid single-beat writers
    for (int c = 0; c < 6; c++) begin
      int g;
      g = c % 3;
      #1;
      chk("rr_ready", 64'(req_ready), 64'(1) << g);
      chk("rr_addr", 64'(data_dma_addr), 64'(16'h0100 + 16'(g * 8)));
      chk("rr_wen", 64'(data_dma_wen), 64'hFF);
      chk("rr_wdata", data_dma_wr_data, wdata_of(g, 16'h0100 + 16'(g * 8)));
      tick();
    end

    // Move the pointer to port 1, then a 4-beat burst from port 1 with a gap
    clear_all();
    set_port(0, 1'b0, 8'h0F, 16'h0200, 1'b1);
    #1;
    chk("pre_burst_ready", 64'(req_ready), 64'b001);
    tick();
    set_port(0, 1'b0, 8'h0F, 16'h0200, 1'b1);
    set_port(2, 1'b0, 8'hF0, 16'h0210, 1'b1);
    set_port(1, 1'b0, 8'h3C, 16'h0300, 1'b0);
    #1;
    chk("burst_b0_ready", 64'(req_ready), 64'b010);
    tick();
    set_port(1, 1'b0, 8'h3C, 16'h0308, 1'b0);
    #1;
    chk("burst_b1_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("burst_gap_ready", 64'(req_ready), 64'b000);
    chk("burst_gap_en", 64'(data_dma_en), 64'h0);
    tick();
    set_port(1, 1'b0, 8'h3C, 16'h0310, 1'b0);
    #1;
    chk("burst_b2_ready", 64'(req_ready), 64'b010);
    tick();
    set_port(1, 1'b0, 8'h3C, 16'h0318, 1'b1);
    #1;
    chk("burst_b3_ready", 64'(req_ready), 64'b010);
    chk("burst_b3_addr", 64'(data_dma_addr), 64'h0318);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("post_burst_ready", 64'(req_ready), 64'b100);
    tick();

    // Back-to-back reads, responses in issue order after two cycles
    clear_all();
    set_port(2, 1'b1, 8'h00, 16'h0040, 1'b1);
    #1;
    chk("rd2_ready", 64'(req_ready), 64'b100);
    chk("rd2_ren", 64'(data_dma_ren), 64'h1);
    tick();
    clear_all();
    set_port(0, 1'b1, 8'h00, 16'h0048, 1'b1);
    #1;
    chk("rd0_ready", 64'(req_ready), 64'b001);
    chk("rd0_rsp_valid_early", 64'(rsp_valid), 64'h0);
    tick();
    clear_all();
    #1;
    chk("rsp2_valid", 64'(rsp_valid), 64'b100);
    chk("rsp2_data", rsp_data, mem_of(16'h0040));
    tick();
    #1;
    chk("rsp0_valid", 64'(rsp_valid), 64'b001);
    chk("rsp0_data", rsp_data, mem_of(16'h0048));
    tick();
    #1;
    chk("rsp_idle_valid", 64'(rsp_valid), 64'h0);
    chk("rsp_idle_data", rsp_data, 64'h0);

    // Out-of-bound read from port 0
    set_port(0, 1'b1, 8'h00, 16'h8000, 1'b1);
    #1;
    chk("oob_ready", 64'(req_ready), 64'b001);
    chk("oob_en", 64'(data_dma_en), 64'h0);
    chk("oob_ren", 64'(data_dma_ren), 64'h0);
    chk("oob_addr", 64'(data_dma_addr), 64'h0);
    chk("oob_err_before", 64'(err_oob), 64'h0);
    tick();
    clear_all();
    #1;
    chk("oob_err_set", 64'(err_oob), 64'h1);
    chk("oob_err_port0", 64'(err_port), 64'h0);
    tick();
    #1;
    chk("oob_rsp_valid", 64'(rsp_valid), 64'b001);
    chk("oob_rsp_data", rsp_data, 64'h0);

    // Clear alone, new error on port 1, then clear racing a port-2 error
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #1;
    chk("clr_err_oob", 64'(err_oob), 64'h0);
    chk("clr_err_port", 64'(err_port), 64'h0);
    set_port(1, 1'b0, 8'hFF, 16'hFFF8, 1'b1);
    #1;
    chk("oob1_ready", 64'(req_ready), 64'b010);
    chk("oob1_en", 64'(data_dma_en), 64'h0);
    tick();
    clear_all();
    #1;
    chk("oob1_err_oob", 64'(err_oob), 64'h1);
    chk("oob1_err_port", 64'(err_port), 64'h1);
    err_clear = 1'b1;
    set_port(2, 1'b0, 8'hFF, 16'h9000, 1'b1);
    tick();
    err_clear = 1'b0;
    clear_all();
    #1;
    chk("race_err_oob", 64'(err_oob), 64'h1);
    chk("race_err_port", 64'(err_port), 64'h2);
    set_port(0, 1'b0, 8'hFF, 16'hA000, 1'b1);
    tick();
    clear_all();
    #1;
    chk("sticky_err_port", 64'(err_port), 64'h2);

    // Reset mid-burst with two reads in flight
    set_port(0, 1'b1, 8'h00, 16'h0010, 1'b0);
    tick();
    set_port(0, 1'b1, 8'h00, 16'h0018, 1'b0);
    #1;
    chk("mid_burst_ready", 64'(req_ready), 64'b001);
    tick();
    rst = 1'b1;
    clear_all();
    set_port(1, 1'b0, 8'hFF, 16'h0020, 1'b1);
    #1;
    chk("rst2_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst2_ready", 64'(req_ready), 64'h0);
    chk("rst2_err_oob", 64'(err_oob), 64'h0);
    tick();
    rst = 1'b0;
    clear_all();
    #1;
    chk("post_rst_rsp_a", 64'(rsp_valid), 64'h0);
    tick();
    #1;
    chk("post_rst_rsp_b", 64'(rsp_valid), 64'h0);
    set_port(2, 1'b0, 8'hFF, 16'h0030, 1'b1);
    #1;
    chk("post_rst_grant2", 64'(req_ready), 64'b100);
    chk("post_rst_addr", 64'(data_dma_addr), 64'h0030);
    tick();
    clear_all();
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_dma_arbiter.md
Name: dmem_dma_arbiter

Overview:
- Shares the single data-memory DMA port of one RISC-V core slot (data_dma_en/ren/wen/addr/wr_data/rd_data) between PORTS requesters, e.g. packet ingress writer, packet egress reader and host/debug access.
- Round-robin arbitration with optional burst lock.
- Routes read data back to the requester that issued the read, after the fixed memory read latency.
- Rejects out-of-range addresses locally, without driving memory, and flags them with a sticky error.

Parameters:
- PORTS, 3, number of requesters (2..8).
- DATA_WIDTH, 64, memory line width in bits.
- STRB_WIDTH, DATA_WIDTH/8, byte-enable width.
- ADDR_WIDTH, 16, requester and DMA byte-address width.
- DMEM_SIZE_BYTES, 32768, data-memory size; DMEM_ADDR_WIDTH = $clog2(DMEM_SIZE_BYTES).
- RD_LATENCY, 1, cycles from memory enable to valid data_dma_rd_data (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  PORTS  request valid per port.
- req_ready  out  PORTS  request accepted this cycle; one-hot or zero.
- req_last  in  PORTS  last beat of a locked burst; 1 for single beats.
- req_ren  in  PORTS  read request.
- req_wen  in  PORTS*STRB_WIDTH  byte write enables, port p at [p*STRB_WIDTH +: STRB_WIDTH].
- req_addr  in  PORTS*ADDR_WIDTH  byte address per port.
- req_wr_data  in  PORTS*DATA_WIDTH  write data per port.
- rsp_valid  out  PORTS  read data valid for port p (one-hot or zero).
- rsp_data  out  DATA_WIDTH  shared read-data bus.
- data_dma_en  out  1  memory enable.
- data_dma_ren  out  1  memory read enable.
- data_dma_wen  out  STRB_WIDTH  memory byte write enables.
- data_dma_addr  out  ADDR_WIDTH  memory byte address.
- data_dma_wr_data  out  DATA_WIDTH  memory write data.
- data_dma_rd_data  in  DATA_WIDTH  memory read data.
- err_oob  out  1  sticky out-of-bound flag.
- err_port  out  $clog2(PORTS)  port index of the first out-of-bound request.
- err_clear  in  1  clears err_oob and err_port.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, lock_port=0, read pipeline cleared, err_oob=0, err_port=0. While rst is high: req_ready=0, rsp_valid=0, data_dma_en=0.
- Arbitration is combinational from req_valid. Accept = req_valid[p] && req_ready[p]. At most one accept per cycle; no bubble between back-to-back accepts.
- IDLE:
  - Grant the first valid port at or after rr_ptr, searching upward with wrap.
  - On accept: rr_ptr <= grant+1 mod PORTS.
  - If req_last=0 on the accepted beat: state <= LOCKED, lock_port <= grant.
- LOCKED:
  - Only lock_port may be granted; other ports see ready=0.
  - Accept with req_last=1: state <= IDLE.
  - lock_port not valid: idle cycle, lock is held.
- Forwarding of an accepted in-range request (|addr[ADDR_WIDTH-1:DMEM_ADDR_WIDTH]==0):
  - data_dma_en=1.
  - ren, wen, addr and wr_data are copied combinationally from the granted port.
  - Otherwise data_dma_en=0, ren=0, wen=0, addr=0, wr_data=0.
- Accepted request with ren=0 and wen=0: forwarded as en=1 with no read, write or response.
- Out of bound (any upper address bit set):
  - Request is still accepted; data_dma_en=0.
  - If err_oob=0: set err_oob=1, err_port=p.
  - A read still returns a response, with rsp_data=0.
  - Lock and burst state advance normally.
- err_clear and a new error in the same cycle: the new error wins, err_port = new port.
- Read pipeline: RD_LATENCY-deep shift register of {valid, port, oob}, loaded on every accept with ren=1.
  - At the tail: rsp_valid[port]=1; rsp_data = oob ? 0 : data_dma_rd_data.
  - With no response at the tail: rsp_valid=0 and rsp_data=0.
  - Requesters are always ready for responses; there is no backpressure.
- Read and write in the same beat (ren=1, wen!=0): both are forwarded; one response is returned.
- Responses are in issue order. Ports with no outstanding read never see rsp_valid.
- rst asserted mid-burst: lock and in-flight responses are dropped; no rsp_valid until new accepts.

Decomposition:
- Shared package: PORT_IDX_W = $clog2(PORTS) and the arbiter state encoding (IDLE=0, LOCKED=1).
- One sub-module, rr_arbiter (request vector, pointer -> one-hot grant plus index), reusable by other shared-port blocks.
- The read-tag pipeline stays inline.

Test Plan:
- Ports 0,1,2 hold valid single-beat writes for 6 cycles -> grants 0,1,2,0,1,2; data_dma_wen/addr match the granted port each cycle.
- Port 1 issues a 4-beat burst (last on beat 4) while ports 0 and 2 are valid -> port 1 gets 4 consecutive grants; next grant is port 2.
- RD_LATENCY=2: port 2 reads addr 0x0040, then port 0 reads addr 0x0048 on the next cycle -> rsp_valid=3'b100 at t+2 and 3'b001 at t+3, each carrying the memory model data.
- Port 0 reads addr 0x8000 (DMEM 32 KiB) -> data_dma_en=0, err_oob=1, err_port=0, rsp_valid[0] after RD_LATENCY with rsp_data=0.
- err_clear pulsed alone -> err_oob=0; later error on port 1 -> err_port=1.
- rst pulsed mid-burst with 2 reads in flight -> no rsp_valid afterwards; state IDLE, rr_ptr=0; the next request from port 2 is granted immediately.
